// File: rtl/rsp_encode.sv
// rsp_encode: response framer between the read-data FIFO and uart_tx.
// Pulls BURST_LEN 16-bit words from rfifo per trigger and streams
// HEADER, length, payload (MSB byte first) over a valid/ready byte port.
// Optional build macro RSP_CHKSUM_EN appends an XOR checksum byte.
module rsp_encode #(
  parameter int unsigned BURST_LEN = 4,
  parameter logic [7:0]  HEADER    = 8'hAA
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rsp_trig,
  input  logic        rfifo_empty,
  output logic        rfifo_rd_en,
  input  logic [15:0] rfifo_rd_data,
  output logic [7:0]  tx_data,
  output logic        tx_vld,
  input  logic        tx_rdy,
  output logic        busy,
  output logic        frame_done,
  output logic        trig_drop
);

  localparam int unsigned CNT_W    = $clog2(BURST_LEN + 1);
  localparam logic [7:0]  LEN_BYTE = 8'(2 * BURST_LEN);

`ifdef RSP_CHKSUM_EN
  typedef enum logic [3:0] {
    IDLE, HDR, LEN, FETCH, WAIT, SEND_HI, SEND_LO, CHK, DONE
  } state_t;
`else
  typedef enum logic [3:0] {
    IDLE, HDR, LEN, FETCH, WAIT, SEND_HI, SEND_LO, DONE
  } state_t;
`endif

  state_t             state_q, state_d;
  logic               pending_q, pending_d;
  logic               trig_drop_q, trig_drop_d;
  logic               rd_en_q, rd_en_d;
  logic               tx_vld_q, tx_vld_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               busy_q, busy_d;
  logic               frame_done_q, frame_done_d;
  logic [7:0]         lo_q, lo_d;
  logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
`ifdef RSP_CHKSUM_EN
  logic [7:0]         chk_q, chk_d;
`endif
  logic               xfer;

  assign xfer = tx_vld_q && tx_rdy;

  // Next-state, trigger arbitration and registered-output computation
  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    trig_drop_d  = trig_drop_q;
    rd_en_d      = 1'b0;
    tx_vld_d     = tx_vld_q;
    tx_data_d    = tx_data_q;
    frame_done_d = 1'b0;
    lo_d         = lo_q;
    word_cnt_d   = word_cnt_q;
`ifdef RSP_CHKSUM_EN
    chk_d        = chk_q;
`endif

    // A trigger during a frame queues one deep; any further one is lost
    if (rsp_trig && (state_q != IDLE)) begin
      if (pending_q) trig_drop_d = 1'b1;
      else           pending_d   = 1'b1;
    end

    // rfifo_rd_en is registered, so it is raised on entry to FETCH; the
    // FIFO is only drained by us, so not-empty cannot go stale meanwhile.
    case (state_q)
      IDLE: begin
        if (rsp_trig || pending_q) begin
          pending_d = pending_q && rsp_trig;
          tx_data_d = HEADER;
          tx_vld_d  = 1'b1;
          state_d   = HDR;
        end
      end
      HDR: begin
        if (xfer) begin
          tx_data_d = LEN_BYTE;
          state_d   = LEN;
        end
      end
      LEN: begin
        if (xfer) begin
`ifdef RSP_CHKSUM_EN
          chk_d = chk_q ^ tx_data_q;
`endif
          tx_vld_d = 1'b0;
          rd_en_d  = !rfifo_empty;
          state_d  = FETCH;
        end
      end
      FETCH: begin
        if (rd_en_q) state_d = WAIT;
        else         rd_en_d = !rfifo_empty;
      end
      WAIT: begin
        // High byte goes straight to tx_data; low byte is held for SEND_LO
        lo_d      = rfifo_rd_data[7:0];
        tx_data_d = rfifo_rd_data[15:8];
        tx_vld_d  = 1'b1;
        state_d   = SEND_HI;
      end
      SEND_HI: begin
        if (xfer) begin
`ifdef RSP_CHKSUM_EN
          chk_d = chk_q ^ tx_data_q;
`endif
          tx_data_d = lo_q;
          state_d   = SEND_LO;
        end
      end
      SEND_LO: begin
        if (xfer) begin
`ifdef RSP_CHKSUM_EN
          chk_d = chk_q ^ tx_data_q;
`endif
          word_cnt_d = word_cnt_q + CNT_W'(1);
          if (word_cnt_d == CNT_W'(BURST_LEN)) begin
`ifdef RSP_CHKSUM_EN
            tx_data_d = chk_d;
            state_d   = CHK;
`else
            tx_vld_d     = 1'b0;
            frame_done_d = 1'b1;
            state_d      = DONE;
`endif
          end else begin
            tx_vld_d = 1'b0;
            rd_en_d  = !rfifo_empty;
            state_d  = FETCH;
          end
        end
      end
`ifdef RSP_CHKSUM_EN
      CHK: begin
        if (xfer) begin
          tx_vld_d     = 1'b0;
          frame_done_d = 1'b1;
          state_d      = DONE;
        end
      end
`endif
      DONE: begin
        word_cnt_d = '0;
`ifdef RSP_CHKSUM_EN
        chk_d = 8'h00;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE) || pending_d;
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pending_q    <= 1'b0;
      trig_drop_q  <= 1'b0;
      rd_en_q      <= 1'b0;
      tx_vld_q     <= 1'b0;
      tx_data_q    <= 8'h00;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      lo_q         <= 8'h00;
      word_cnt_q   <= '0;
`ifdef RSP_CHKSUM_EN
      chk_q        <= 8'h00;
`endif
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      trig_drop_q  <= trig_drop_d;
      rd_en_q      <= rd_en_d;
      tx_vld_q     <= tx_vld_d;
      tx_data_q    <= tx_data_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      lo_q         <= lo_d;
      word_cnt_q   <= word_cnt_d;
`ifdef RSP_CHKSUM_EN
      chk_q        <= chk_d;
`endif
    end
  end

  assign rfifo_rd_en = rd_en_q;
  assign tx_data     = tx_data_q;
  assign tx_vld      = tx_vld_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign trig_drop   = trig_drop_q;

endmodule
